tlb_op_ctrl: RTL and testbench
==============================

// Module: tlb_op_ctrl
// PURPOSE
//  Sequences the TLB maintenance instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB onto the address-translation unit.
//  - Before any access, drains in-flight inst/data translations and holds off new ones.
//  - Issues one-cycle strobes to the TLB ports, captures TLBSRCH results for CSR writeback, and supplies the TLBFILL index.
//  - Sits between the commit stage / CSR unit and the address-translation unit.
// PARAMETERS
//  TLBNUM   32   number of TLB entries; IDX_W = $clog2(TLBNUM) is a localparam
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high
//  flush        in   1      pipeline flush (exception | ertn | branch)
//  op_valid     in   1      maintenance op request from commit
//  op_ready     out  1      op accepted when op_valid & op_ready
//  op_code      in   3      1=SRCH 2=RD 3=WR 4=FILL 5=INV; others=NOP
//  inv_op       in   5      INVTLB op field
//  inv_asid     in   10     INVTLB asid operand
//  inv_vpn      in   19     INVTLB vppn operand
//  op_done      out  1      1-cycle pulse: op complete, commit may retire
//  op_err       out  1      valid with op_done: INVTLB with inv_op>6 (INE)
//  inst_busy    in   1      inst translation stage holds a valid entry
//  data_busy    in   1      data translation stage holds a valid entry
//  hold_req     out  1      block new inst/data translation requests
//  tlbsrch_en   out  1      search strobe to data search port
//  tlb_wen      out  1      TLBWR strobe
//  tlb_fill_en  out  1      TLBFILL strobe
//  rand_index   out  IDX_W  TLBFILL victim index
//  tlbinv_en    out  1      INVTLB strobe
//  tlbinv_op    out  5      registered inv_op
//  tlbinv_asid  out  10     registered inv_asid
//  tlbinv_vpn   out  19     registered inv_vpn
//  srch_found   in   1      search hit, valid 1 cycle after tlbsrch_en
//  srch_index   in   IDX_W  search hit index, same timing as srch_found
//  srch_we      out  1      CSR TLBIDX writeback strobe for TLBSRCH
//  srch_hit     out  1      with srch_we: 1 -> write INDEX and clear NE; 0 -> set NE
//  srch_idx_o   out  IDX_W  with srch_we: index to write
//  rd_we        out  1      CSR strobe: latch TLB read-port outputs (TLBRD)
// BEHAVIOUR
//  States: IDLE, DRAIN, ISSUE, WAIT, DONE.
//  - Reset: state=IDLE; all strobes, op_done, op_err, hold_req and srch_* outputs = 0; tlbinv_* = 0.
//  - op_ready = (state==IDLE); it is 1 in the first cycle after reset.
//  - IDLE: on accept, register op_code and inv_* -> DRAIN. hold_req=1 in every state except IDLE.
//  - DRAIN: stay while inst_busy|data_busy. When both are 0 -> ISSUE (minimum 1 cycle in DRAIN).
//  - DRAIN + flush: abort -> IDLE; no strobe, no op_done.
//  - ISSUE, exactly one cycle; flush is ignored from ISSUE onward:
//    - SRCH: tlbsrch_en=1 -> WAIT.
//    - RD: rd_we=1 -> DONE.
//    - WR: tlb_wen=1 -> WAIT.
//    - FILL: tlb_fill_en=1, rand_index held stable this cycle -> WAIT.
//    - INV with inv_op<=6: tlbinv_en=1 -> WAIT.
//    - INV with inv_op>6: no strobe, op_err=1 -> DONE.
//    - NOP codes: no strobe -> DONE.
//  - WAIT, one cycle:
//    - SRCH: srch_we=1, srch_hit=srch_found, srch_idx_o=srch_index.
//    - Other ops: this cycle only lets the TLB write land.
//    - Then -> DONE.
//  - DONE: op_done=1 (op_err valid with it) -> IDLE.
//  - Latency, accept to op_done with no drain stall: RD 3 cycles; SRCH, WR, FILL, INV 4 cycles.
//  - Strobes are mutually exclusive and never asserted outside ISSUE. srch_we and rd_we are never asserted together.
//  - rand_index, default: free-running IDX_W counter, +1 every cycle, wraps TLBNUM-1 -> 0, resets to 0.
//  - op_valid outside IDLE is not accepted and has no effect.
// CONFIGURATION
//  TLB_FILL_LFSR_EN
//  - Defined: rand_index comes from a 5-bit Fibonacci LFSR, taps x^5+x^3+1.
//    - Seed 5'h1F at reset; advances every cycle; never 0.
//    - Requires TLBNUM==32; $error at elaboration otherwise.
//  - Undefined: the wrapping counter above.
// STRUCTURE
//  Package tlb_pkg:
//  - typedef enum tlb_op_e: NOP=0, SRCH=1, RD=2, WR=3, FILL=4, INV=5.
//  - typedef enum tlb_ctrl_state_e.
//  - TLBNUM default and INV_OP_MAX=6.
//  Sub-module tlb_rand_gen (clk, reset, rand_index): counter or LFSR selected by TLB_FILL_LFSR_EN.
//  FSM and operand registers stay in tlb_op_ctrl.
// TESTING
//  1. SRCH, busy=0; srch_found=1, srch_index=7 in WAIT -> tlbsrch_en at T+2, srch_we/hit=1/idx=7 at T+3, op_done at T+4.
//  2. WR with data_busy=1 for 5 cycles -> hold_req=1 throughout; tlb_wen 1 cycle after data_busy falls; op_done 2 cycles later.
//  3. INV inv_op=7 -> no tlbinv_en; op_done=1 with op_err=1 at T+3.
//  4. FILL, flush during DRAIN (inst_busy=1) -> back to IDLE, no tlb_fill_en, no op_done, op_ready=1 next cycle.
//  5. Reset, then 33 cycles idle -> rand_index counts 0..31 then 0; with TLB_FILL_LFSR_EN: 31 distinct nonzero values, period 31.
//  6. RD, then op_valid held high during the op -> rd_we at T+2, op_done at T+3, second op accepted only when back in IDLE.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared types and constants for the TLB maintenance-op sequencer.
package tlb_pkg;

    localparam int TLBNUM_DEF = 32;
    localparam logic [4:0] INV_OP_MAX = 5'd6;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        SRCH = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        FILL = 3'd4,
        INV  = 3'd5
    } tlb_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } tlb_ctrl_state_e;

endpackage

// File: rtl/tlb_rand_gen.sv
// TLBFILL victim index source: wrapping counter, or 5-bit LFSR when TLB_FILL_LFSR_EN is defined.
module tlb_rand_gen #(
    parameter int TLBNUM = 32,
    parameter int IDX_W  = $clog2(TLBNUM)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [IDX_W-1:0] rand_index
);

`ifdef TLB_FILL_LFSR_EN
    if (TLBNUM != 32) begin : g_bad_tlbnum
        $error("tlb_rand_gen: LFSR victim selection needs TLBNUM == 32");
    end

    logic [4:0] lfsr_q;
    logic [4:0] lfsr_d;

    // x^5 + x^3 + 1: all-ones seed keeps the register out of the zero lock-up state
    assign lfsr_d = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 5'h1F;
        else       lfsr_q <= lfsr_d;
    end

    assign rand_index = IDX_W'(lfsr_q);
`else
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;

    assign cnt_d = (cnt_q == IDX_W'(TLBNUM - 1)) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign rand_index = cnt_q;
`endif

endmodule

// File: rtl/tlb_op_ctrl.sv
// Drains translations, then strobes one TLB maintenance op and reports completion.
// Optional macro TLB_FILL_LFSR_EN selects LFSR-based TLBFILL index (see tlb_rand_gen).
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter int TLBNUM = TLBNUM_DEF,
    localparam int IDX_W = $clog2(TLBNUM)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [4:0]       inv_op,
    input  logic [9:0]       inv_asid,
    input  logic [18:0]      inv_vpn,
    output logic             op_done,
    output logic             op_err,
    input  logic             inst_busy,
    input  logic             data_busy,
    output logic             hold_req,
    output logic             tlbsrch_en,
    output logic             tlb_wen,
    output logic             tlb_fill_en,
    output logic [IDX_W-1:0] rand_index,
    output logic             tlbinv_en,
    output logic [4:0]       tlbinv_op,
    output logic [9:0]       tlbinv_asid,
    output logic [18:0]      tlbinv_vpn,
    input  logic             srch_found,
    input  logic [IDX_W-1:0] srch_index,
    output logic             srch_we,
    output logic             srch_hit,
    output logic [IDX_W-1:0] srch_idx_o,
    output logic             rd_we
);

    tlb_ctrl_state_e state_q, state_d;
    logic [2:0]      op_q;
    logic [4:0]      inv_op_q;
    logic [9:0]      inv_asid_q;
    logic [18:0]     inv_vpn_q;
    logic            inv_bad;
    logic            accept;

    assign accept  = op_valid && (state_q == ST_IDLE);
    assign inv_bad = (op_q == INV) && (inv_op_q > INV_OP_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= NOP;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_vpn_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q       <= op_code;
                inv_op_q   <= inv_op;
                inv_asid_q <= inv_asid;
                inv_vpn_q  <= inv_vpn;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        op_ready    = 1'b0;
        hold_req    = 1'b1;
        op_done     = 1'b0;
        op_err      = 1'b0;
        tlbsrch_en  = 1'b0;
        tlb_wen     = 1'b0;
        tlb_fill_en = 1'b0;
        tlbinv_en   = 1'b0;
        rd_we       = 1'b0;
        srch_we     = 1'b0;
        srch_hit    = 1'b0;
        srch_idx_o  = '0;
        case (state_q)
            ST_IDLE: begin
                op_ready = 1'b1;
                hold_req = 1'b0;
                if (op_valid) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // flush wins over a finished drain: nothing has touched the TLB yet
                if (flush)                         state_d = ST_IDLE;
                else if (!inst_busy && !data_busy) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                case (op_q)
                    SRCH: tlbsrch_en  = 1'b1;
                    RD: begin
                        rd_we   = 1'b1;
                        state_d = ST_DONE;
                    end
                    WR:   tlb_wen     = 1'b1;
                    FILL: tlb_fill_en = 1'b1;
                    INV: begin
                        if (inv_bad) state_d   = ST_DONE;
                        else         tlbinv_en = 1'b1;
                    end
                    default: state_d = ST_DONE;
                endcase
            end
            ST_WAIT: begin
                if (op_q == SRCH) begin
                    srch_we    = 1'b1;
                    srch_hit   = srch_found;
                    srch_idx_o = srch_found ? srch_index : '0;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                op_done = 1'b1;
                op_err  = inv_bad;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tlbinv_op   = inv_op_q;
    assign tlbinv_asid = inv_asid_q;
    assign tlbinv_vpn  = inv_vpn_q;

    tlb_rand_gen #(
        .TLBNUM (TLBNUM),
        .IDX_W  (IDX_W)
    ) u_rand_gen (
        .clk        (clk),
        .reset      (reset),
        .rand_index (rand_index)
    );

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: op sequencing, drain/flush, INVTLB error, fill-index source.
module tb_tlb_op_ctrl;

    localparam int IDX_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_code;
    logic [4:0]       inv_op;
    logic [9:0]       inv_asid;
    logic [18:0]      inv_vpn;
    logic             op_done;
    logic             op_err;
    logic             inst_busy;
    logic             data_busy;
    logic             hold_req;
    logic             tlbsrch_en;
    logic             tlb_wen;
    logic             tlb_fill_en;
    logic [IDX_W-1:0] rand_index;
    logic             tlbinv_en;
    logic [4:0]       tlbinv_op;
    logic [9:0]       tlbinv_asid;
    logic [18:0]      tlbinv_vpn;
    logic             srch_found;
    logic [IDX_W-1:0] srch_index;
    logic             srch_we;
    logic             srch_hit;
    logic [IDX_W-1:0] srch_idx_o;
    logic             rd_we;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tlb_op_ctrl #(.TLBNUM(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_code     (op_code),
        .inv_op      (inv_op),
        .inv_asid    (inv_asid),
        .inv_vpn     (inv_vpn),
        .op_done     (op_done),
        .op_err      (op_err),
        .inst_busy   (inst_busy),
        .data_busy   (data_busy),
        .hold_req    (hold_req),
        .tlbsrch_en  (tlbsrch_en),
        .tlb_wen     (tlb_wen),
        .tlb_fill_en (tlb_fill_en),
        .rand_index  (rand_index),
        .tlbinv_en   (tlbinv_en),
        .tlbinv_op   (tlbinv_op),
        .tlbinv_asid (tlbinv_asid),
        .tlbinv_vpn  (tlbinv_vpn),
        .srch_found  (srch_found),
        .srch_index  (srch_index),
        .srch_we     (srch_we),
        .srch_hit    (srch_hit),
        .srch_idx_o  (srch_idx_o),
        .rd_we       (rd_we)
    );

    // Inputs change 3 time units after a rising edge; outputs are checked at the same point.
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {tlbsrch_en, tlb_wen, tlb_fill_en, tlbinv_en, rd_we};
    endfunction

    logic [IDX_W-1:0] vals [0:31];
    int dups;

    initial begin
        reset = 1'b1; flush = 1'b0; op_valid = 1'b0; op_code = 3'd0;
        inv_op = '0; inv_asid = '0; inv_vpn = '0;
        inst_busy = 1'b0; data_busy = 1'b0; srch_found = 1'b0; srch_index = '0;

        // reset state
        tick(); tick();
        chk("rst_op_ready", op_ready, 1'b1);
        chk("rst_hold_req", hold_req, 1'b0);
        chk("rst_done_err", {op_done, op_err}, 2'b00);
        chk("rst_strobes", strobes(), 5'b0);
        chk("rst_srch", {srch_we, srch_hit, srch_idx_o}, 7'b0);
        chk("rst_inv_regs", {tlbinv_op, tlbinv_asid, tlbinv_vpn}, 34'b0);

        // fill index source across a full wrap
        vals[0] = rand_index;
        reset = 1'b0;
`ifdef TLB_FILL_LFSR_EN
        chk("rnd_seed", rand_index, 5'h1F);
        for (int i = 1; i < 32; i++) begin
            tick();
            vals[i] = rand_index;
        end
        dups = 0;
        for (int i = 0; i < 31; i++) begin
            if (vals[i] == '0) dups++;
            for (int j = i + 1; j < 31; j++)
                if (vals[i] == vals[j]) dups++;
        end
        chk("lfsr_nonzero_distinct", dups, 0);
        chk("lfsr_period31", vals[31], vals[0]);
`else
        chk("rnd_reset", rand_index, 5'd0);
        dups = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (rand_index !== 5'(i % 32)) dups++;
        end
        chk("rnd_count_wrap", dups, 0);
        chk("rnd_after_wrap", rand_index, 5'd0);
`endif

        // 1. TLBSRCH hit at index 7
        op_code = 3'd1; op_valid = 1'b1; srch_found = 1'b1; srch_index = 5'd7;
        chk("srch_ready", op_ready, 1'b1);
        tick(); op_valid = 1'b0;
        chk("srch_t1_hold", {hold_req, op_ready}, 2'b10);
        chk("srch_t1_strb", strobes(), 5'b0);
        tick();
        chk("srch_t2_strb", strobes(), 5'b10000);
        tick();
        chk("srch_t3_wb", {srch_we, srch_hit, srch_idx_o}, {2'b11, 5'd7});
        chk("srch_t3_strb", strobes(), 5'b0);
        tick();
        chk("srch_t4_done", {op_done, op_err, srch_we}, 3'b100);
        tick(); srch_found = 1'b0; srch_index = '0;
        chk("srch_idle", {op_ready, op_done, hold_req}, 3'b100);

        // search miss: NE path
        op_code = 3'd1; op_valid = 1'b1; srch_index = 5'd9;
        tick(); op_valid = 1'b0;
        tick(); tick();
        chk("miss_wb", {srch_we, srch_hit}, 2'b10);
        tick(); tick();

        // 2. TLBWR with data_busy high for 5 cycles
        op_code = 3'd3; op_valid = 1'b1; data_busy = 1'b1;
        tick(); op_valid = 1'b0;
        dups = 0;
        for (int i = 0; i < 5; i++) begin
            if (hold_req !== 1'b1 || strobes() !== 5'b0) dups++;
            if (i == 4) data_busy = 1'b0;
            else tick();
        end
        chk("wr_drain_hold", dups, 0);
        tick();
        chk("wr_issue", strobes(), 5'b01000);
        tick();
        chk("wr_wait", {strobes(), hold_req, op_done}, 7'b0000010);
        tick();
        chk("wr_done", {op_done, op_err}, 2'b10);
        tick();

        // 3. INVTLB with inv_op=7 -> INE, no strobe
        op_code = 3'd5; inv_op = 5'd7; inv_asid = 10'h155; inv_vpn = 19'h4ABCD; op_valid = 1'b1;
        tick(); op_valid = 1'b0;
        chk("inv7_regs", {tlbinv_op, tlbinv_asid, tlbinv_vpn}, {5'd7, 10'h155, 19'h4ABCD});
        tick();
        chk("inv7_issue", {strobes(), op_done}, 6'b0);
        tick();
        chk("inv7_done", {op_done, op_err, tlbinv_en}, 3'b110);
        tick();

        // INVTLB with inv_op=6 (largest legal)
        op_code = 3'd5; inv_op = 5'd6; inv_asid = 10'h2A; inv_vpn = 19'h12345; op_valid = 1'b1;
        tick(); op_valid = 1'b0; inv_op = 5'd0;
        tick();
        chk("inv6_issue", {strobes(), tlbinv_op}, {5'b00010, 5'd6});
        tick();
        chk("inv6_wait", {strobes(), op_done}, 6'b0);
        tick();
        chk("inv6_done", {op_done, op_err}, 2'b10);
        tick();

        // 4. TLBFILL aborted by flush while draining
        op_code = 3'd4; op_valid = 1'b1; inst_busy = 1'b1;
        tick(); op_valid = 1'b0;
        chk("fill_drain", {hold_req, strobes()}, 6'b100000);
        tick();
        flush = 1'b1;
        tick(); flush = 1'b0; inst_busy = 1'b0;
        chk("fill_flush_idle", {op_ready, hold_req, op_done, strobes()}, 8'b10000000);
        tick();
        chk("fill_flush_quiet", {op_ready, op_done, strobes()}, 7'b1000000);

        // TLBFILL completing normally
        op_code = 3'd4; op_valid = 1'b1;
        tick(); op_valid = 1'b0;
        tick();
        chk("fill_issue", strobes(), 5'b00100);
        tick(); tick();
        chk("fill_done", {op_done, op_err}, 2'b10);
        tick();

        // NOP code 6 -> done after ISSUE, no strobe
        op_code = 3'd6; op_valid = 1'b1;
        tick(); op_valid = 1'b0;
        tick();
        chk("nop_issue", strobes(), 5'b0);
        tick();
        chk("nop_done", {op_done, op_err}, 2'b10);
        tick();

        // 6. TLBRD with op_valid held; second op (WR) taken only from IDLE
        op_code = 3'd2; op_valid = 1'b1;
        tick(); op_code = 3'd3;
        chk("rd_t1", {op_ready, strobes()}, 6'b0);
        tick();
        chk("rd_t2", {strobes(), srch_we}, 6'b000010);
        tick();
        chk("rd_t3_done", {op_done, op_ready, strobes()}, 7'b1000000);
        tick();
        chk("rd_back_idle", op_ready, 1'b1);
        tick(); op_valid = 1'b0;
        chk("rd_second_drain", {op_ready, hold_req}, 2'b01);
        tick();
        chk("rd_second_issue", strobes(), 5'b01000);
        tick(); tick();
        chk("rd_second_done", op_done, 1'b1);
        tick();
        chk("final_idle", {op_ready, hold_req}, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
